// File: rtl/ram_fill_writer_if.sv
// Simple-port RAM write bus: the filler drives a request, the RAM answers with ready.
interface ram_fill_writer_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 64
);
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ready;

  modport master (output wr_en, wr_addr, wr_data, input wr_ready);
  modport slave  (input wr_en, wr_addr, wr_data, output wr_ready);
endinterface

// File: rtl/ram_fill_writer.sv
// Fills DEPTH consecutive RAM words from address 0 with either an address
// pattern or a 64-bit LFSR sequence, one word per accepted beat.
module ram_fill_writer #(
  parameter int          ADDR_W = 10,
  parameter int          DATA_W = 64,
  parameter int          DEPTH  = 1024,
  parameter logic [63:0] SEED   = 64'h1
) (
  input  logic               sys_clk,
  input  logic               rst,
  input  logic               start,
  input  logic               pattern_sel,
  ram_fill_writer_if.master  wr,
  output logic               busy,
  output logic               done
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_t            state;
  logic              lfsr_mode;
  logic [ADDR_W-1:0] next_addr;
  logic [DATA_W-1:0] next_data;
  logic              last_beat;

  // Taps 64,63,61,60 give a maximal-length sequence; shift-left form.
  function automatic logic [63:0] lfsr_step(input logic [63:0] cur);
    return {cur[62:0], cur[63] ^ cur[62] ^ cur[60] ^ cur[59]};
  endfunction

  // NOTE: every output of a combinational block gets a default assignment at
  // the top so no path leaves it unassigned and a latch is never inferred.
  always_comb begin
    next_addr = '0;
    next_data = '0;
    last_beat = 1'b0;
    next_addr = wr.wr_addr + ADDR_W'(1);
    last_beat = (wr.wr_addr == LAST_ADDR);
    if (lfsr_mode) begin
      next_data = DATA_W'(lfsr_step(64'(wr.wr_data)));
    end else begin
      next_data = DATA_W'(next_addr);
    end
  end

  // NOTE: all state here is updated with non-blocking assignments so every
  // register samples the pre-edge values, independent of statement order.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      lfsr_mode  <= 1'b0;
      wr.wr_en   <= 1'b0;
      wr.wr_addr <= '0;
      wr.wr_data <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state      <= ST_WRITE;
            lfsr_mode  <= pattern_sel;
            wr.wr_en   <= 1'b1;
            wr.wr_addr <= '0;
            wr.wr_data <= pattern_sel ? DATA_W'(SEED) : '0;
            busy       <= 1'b1;
          end
        end

        ST_WRITE: begin
          // Without wr_ready every output simply keeps its value.
          if (wr.wr_ready) begin
            if (last_beat) begin
              state      <= ST_DONE;
              wr.wr_en   <= 1'b0;
              wr.wr_addr <= '0;
              wr.wr_data <= '0;
              busy       <= 1'b0;
              done       <= 1'b1;
            end else begin
              wr.wr_addr <= next_addr;
              wr.wr_data <= next_data;
            end
          end
        end

        ST_DONE: begin
          state <= ST_IDLE;
        end

        default: begin
          state    <= ST_IDLE;
          wr.wr_en <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule
